seq_sm_multiplier: RTL and testbench
====================================

Name: seq_sm_multiplier

Overview:
- Parametrised sequential shift-add multiplier; next generation of our combinational 5x5 array multiplier and its sign-magnitude wrapper.
- Operand width is generic; a runtime mode selects sign-magnitude or plain unsigned operands.
- Uses a start/done handshake instead of a flat combinational path.
- Sits between the switch/operand registers and the LED/result display path.

Parameters:
- W, 6, total operand width in bits, including the sign bit in sign-magnitude mode; legal range 3..16.

Ports:
- clk  input  1  system clock; all state is updated on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  input  1  request to begin a multiplication; sampled only in IDLE.
- sm_en  input  1  mode select: 1 = sign-magnitude (bit W-1 is the sign), 0 = unsigned W-bit operands; sampled with start.
- a  input  W  multiplicand; sampled with start.
- b  input  W  multiplier; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  2W  result; held stable until the next accepted start.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, product=0; internal accumulator, operand and counter registers cleared.
- Reset mid-operation aborts the operation. No done pulse follows. product reads 0.
- States: IDLE, RUN.
- IDLE -> RUN on a clock edge with start=1. On that edge:
  - a, b and sm_en are latched.
  - Iteration count N is loaded: N = W-1 if sm_en=1, else N = W.
  - Accumulator is cleared; busy goes high.
- Operand magnitudes:
  - sm_en=1: magnitudes are a[W-2:0] and b[W-2:0]; sign = a[W-1] XOR b[W-1].
  - sm_en=0: magnitudes are the full a and b; sign is not used.
- RUN, one iteration per cycle:
  - If the multiplier shift register LSB is 1, add the multiplicand (zero-extended to 2W bits, shifted by the iteration index) into the accumulator.
  - Then shift the multiplier right by one and decrement the counter.
- Completion: on the edge that executes the final iteration:
  - state -> IDLE, busy -> 0, done -> 1 for exactly one cycle.
  - product is loaded on the same edge.
- Latency: start sampled at edge k; product and done visible after edge k+N. The next start is accepted at edge k+N+1 at the earliest. With start held high, back-to-back operations run every N+1 cycles.
- Product format, sm_en=1:
  - product[2W-3:0] = magnitude product.
  - product[2W-2] = 0.
  - product[2W-1] = sign.
  - Sign is forced to 0 when the magnitude is 0 (no negative zero).
- Product format, sm_en=0: product = full 2W-bit unsigned product.
- Width rule: no overflow is possible; accumulator width is exactly 2W.
- start while busy=1 is ignored. Operand and mode changes during RUN have no effect.
- start and reset asserted together: reset wins.
- done never coincides with busy=1.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: MULT_EARLY_EXIT_EN.
- Defined:
  - In RUN, if the remaining (already shifted) multiplier bits are all zero, the operation completes on that edge; remaining iterations are skipped.
  - A multiplier of 0 completes on the first RUN edge, so latency is 1.
  - Latency is then 1 + index of the highest set magnitude bit of b, minimum 1, maximum N.
  - Product value and all format rules are unchanged.
- Not defined: latency is always exactly N cycles.

Test Plan:
- Sign-magnitude multiply: W=6, sm_en=1, a=6'b0_10111 (+23), b=6'b1_01101 (-13), start 1 cycle -> busy high 5 cycles, done pulse on 5th edge, product=12'h92B (sign 1, magnitude 299).
- Unsigned maximum: W=6, sm_en=0, a=63, b=63 -> done after 6 edges, product=12'hF81 (3969).
- Negative zero: sm_en=1, a=6'b1_00000, b=6'b0_00101 -> product=12'h000, sign bit 0.
- Start during RUN: issue start with a=2, b=3 (sm_en=0), then pulse start with a=7, b=7 two cycles later -> second start ignored; single done; product=6. A start after done with a=7, b=7 -> product=49.
- Reset mid-operation: reset low 1 cycle at RUN iteration 3 -> busy=0, product=0 immediately; no done pulse.
- MULT_EARLY_EXIT_EN defined, sm_en=1, a=6'b0_11111, b=6'b0_00001 -> done after 1 edge, product=31. Same stimulus without the macro -> done after 5 edges, product=31.

Source files
------------

// File: rtl/seq_sm_multiplier.sv
// seq_sm_multiplier: sequential shift-add multiplier with start/done handshake.
// A runtime mode selects sign-magnitude (bit W-1 is the sign) or plain unsigned
// W-bit operands. The product is registered and held until the next accepted start.
// Optional build macro MULT_EARLY_EXIT_EN: when defined, an operation finishes as
// soon as the remaining multiplier bits are all zero. When it is undefined, every
// operation takes exactly N iterations.
module seq_sm_multiplier #(
    parameter int unsigned W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sm_en,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   product
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state, state_d;
    logic [PW-1:0]   acc, acc_d;
    logic [PW-1:0]   mcand, mcand_d;
    logic [W-1:0]    mplier, mplier_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            sign, sign_d;
    logic            sm, sm_d;
    logic            busy_d, done_d;
    logic [PW-1:0]   product_d;

    // Datapath helpers for one shift-add iteration
    logic [PW-1:0]   partial;
    logic [PW-1:0]   sum;
    logic [W-1:0]    mplier_sh;
    logic [PW-3:0]   mag;
    logic            last;

    // Iteration arithmetic: conditional add of the shifted multiplicand
    always_comb begin
        partial   = mplier[0] ? mcand : '0;
        sum       = acc + partial;
        mplier_sh = mplier >> 1;
        mag       = sum[PW-3:0];
`ifdef MULT_EARLY_EXIT_EN
        last      = (cnt == CW'(1)) || (mplier_sh == '0);
`else
        last      = (cnt == CW'(1));
`endif
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            sign    <= 1'b0;
            sm      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            state   <= state_d;
            acc     <= acc_d;
            mcand   <= mcand_d;
            mplier  <= mplier_d;
            cnt     <= cnt_d;
            sign    <= sign_d;
            sm      <= sm_d;
            busy    <= busy_d;
            done    <= done_d;
            product <= product_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state;
        acc_d     = acc;
        mcand_d   = mcand;
        mplier_d  = mplier;
        cnt_d     = cnt;
        sign_d    = sign;
        sm_d      = sm;
        busy_d    = busy;
        done_d    = 1'b0;
        product_d = product;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    acc_d   = '0;
                    sm_d    = sm_en;
                    if (sm_en) begin
                        mcand_d  = PW'(a[W-2:0]);
                        mplier_d = W'(b[W-2:0]);
                        sign_d   = a[W-1] ^ b[W-1];
                        cnt_d    = CW'(W - 1);
                    end else begin
                        mcand_d  = PW'(a);
                        mplier_d = b;
                        sign_d   = 1'b0;
                        cnt_d    = CW'(W);
                    end
                end
            end
            RUN: begin
                acc_d    = sum;
                mcand_d  = mcand << 1;
                mplier_d = mplier_sh;
                cnt_d    = cnt - CW'(1);
                if (last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (sm) begin
                        // Zero magnitude never carries a sign
                        product_d = {sign & (|mag), 1'b0, mag};
                    end else begin
                        product_d = sum;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_sm_multiplier.sv
// Testbench for seq_sm_multiplier: scoreboard of expected products and latencies,
// checked whenever the DUT pulses done.
module tb_seq_sm_multiplier;

    localparam int unsigned W  = 6;
    localparam int unsigned PW = 2 * W;

    logic          clk;
    logic          reset;
    logic          start;
    logic          sm_en;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;

    seq_sm_multiplier #(.W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .sm_en   (sm_en),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    typedef struct {
        logic [PW-1:0] prod;
        int            lat;
        int            k;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference product from plain integer multiplication
    function automatic logic [PW-1:0] model_prod(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [PW-1:0] m;
        if (s) begin
            m = PW'(x[W-2:0]) * PW'(y[W-2:0]);
            return {(x[W-1] ^ y[W-1]) & (m != '0), 1'b0, m[PW-3:0]};
        end
        return PW'(x) * PW'(y);
    endfunction

    function automatic int model_lat(input logic s, input logic [W-1:0] y);
        int n;
        logic [W-1:0] m;
        n = s ? int'(W) - 1 : int'(W);
        m = s ? {1'b0, y[W-2:0]} : y;
`ifdef MULT_EARLY_EXIT_EN
        if (m == '0) return 1;
        for (int i = int'(W) - 1; i >= 0; i--)
            if (m[i]) return i + 1;
        return 1;
`else
        if (m == '1) return n;
        return n;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest scoreboard entry
    always @(negedge clk) begin
        if (reset && done) begin
            check("done_busy", 32'(busy), 32'd0);
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", 32'(product), 32'(e.prod));
                check("latency", 32'(cyc - e.k), 32'(e.lat));
            end
        end
    end

    // Drive one start for a cycle; leaves the bench at the negedge after the accepting edge
    task automatic start_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        @(negedge clk);
        sm_en = s;
        a     = x;
        b     = y;
        start = 1'b1;
        e.prod = model_prod(s, x, y);
        e.lat  = model_lat(s, y);
        e.k    = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done (bounded), counting cycles with busy high
    task automatic wait_done(input string tag, input int exp_busy);
        int bc;
        bool_seen: begin
            bc = 0;
            for (int i = 0; i < 40; i++) begin
                if (done) begin
                    if (exp_busy >= 0) check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
                    disable bool_seen;
                end
                if (busy) bc++;
                @(negedge clk);
            end
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        start_op(s, x, y);
        wait_done(tag, model_lat(s, y));
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        sm_en = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases
        run_op("sm_23xm13", 1'b1, 6'b0_10111, 6'b1_01101);
        check("sm_23xm13_val", 32'(product), 32'h92B);
        run_op("u_63x63", 1'b0, 6'd63, 6'd63);
        check("u_63x63_val", 32'(product), 32'hF81);
        run_op("neg_zero", 1'b1, 6'b1_00000, 6'b0_00101);
        check("neg_zero_val", 32'(product), 32'h000);
        run_op("sm_31x1", 1'b1, 6'b0_11111, 6'b0_00001);
        check("sm_31x1_val", 32'(product), 32'd31);
        run_op("u_x0", 1'b0, 6'd45, 6'd0);
        run_op("sm_negneg", 1'b1, 6'b1_11111, 6'b1_11111);

        // Start during RUN is ignored
        start_op(1'b0, 6'd2, 6'd3);
        @(negedge clk);
        sm_en = 1'b0; a = 6'd7; b = 6'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign", -1);
        check("ign_val", 32'(product), 32'd6);
        repeat (10) @(negedge clk);
        run_op("after_ign", 1'b0, 6'd7, 6'd7);
        check("after_ign_val", 32'(product), 32'd49);

        // Reset mid-operation aborts with no done
        start_op(1'b1, 6'b0_11011, 6'b0_11111);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_product_hold", 32'(product), 32'd0);

        // Randomised operations in both modes
        for (int i = 0; i < 24; i++) begin
            run_op("rnd", 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
        end

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
